// File: rtl/clock_switch_ctrl.sv
// Crypto clock source switch sequencer (usb_clk domain).
// Accepts a source/out-enable request, stalls the crypto core, optionally
// proves the external clock is alive, moves the mux select, waits for the
// mux output to settle and only then re-opens the CW clock output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request, crypto core running
// QUIESCE | hold asserted, waiting for the crypto core to go idle
// CHECK   | counting heartbeat edges of the external clock, bounded by timeout
// SWITCH  | select applied, waiting SETTLE_CYCLES for the mux to settle
// RELEASE | one cycle: done pulse, hold dropped, clock output re-enabled
module clock_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MIN_EDGES      = 4
) (
    input  logic usb_clk,
    input  logic reset,
    input  logic I_req_valid,
    input  logic I_req_src,
    input  logic I_req_out_en,
    output logic O_req_ready,
    input  logic I_crypto_busy,
    input  logic I_ext_heartbeat,
    output logic O_cclk_sel,
    output logic O_cclk_out_en,
    output logic O_crypto_hold,
    output logic O_done,
    output logic O_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_CHECK   = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Settle timer is a down-counter loaded on entry to SWITCH.
    localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  EDGE_TARGET  = 4'(MIN_EDGES);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_req_src;
    logic        r_req_out_en;
    logic        r_prev_out_en;
    logic        r_hb_prev;
    logic [3:0]  r_edge_cnt;
    logic [15:0] r_cyc_cnt;
    logic [7:0]  r_settle_cnt;

    logic        r_sel;
    logic        r_out_en;
    logic        r_hold;
    logic        r_done;
    logic        r_err;
    logic        r_ready;

    logic        w_accept;
    logic        w_hb_edge;
    logic [3:0]  w_edge_nxt;
    logic [15:0] w_cyc_nxt;
    logic [7:0]  w_settle_nxt;
    logic        w_sel_nxt;
    logic        w_out_en_nxt;
    logic        w_hold_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_ready_nxt;

    assign w_accept  = I_req_valid && r_ready;
    assign w_hb_edge = I_ext_heartbeat ^ r_hb_prev;

    // State register.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next-output and counter decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_edge_nxt   = r_edge_cnt;
        w_cyc_nxt    = r_cyc_cnt;
        w_settle_nxt = r_settle_cnt;
        w_sel_nxt    = r_sel;
        w_out_en_nxt = r_out_en;
        w_hold_nxt   = r_hold;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;

        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt  = ST_QUIESCE;
                    w_hold_nxt   = 1'b1;
                    w_out_en_nxt = 1'b0;
                    w_err_nxt    = 1'b0;
                end
            end

            ST_QUIESCE: begin
                w_hold_nxt   = 1'b1;
                w_out_en_nxt = 1'b0;
                if (!I_crypto_busy) begin
                    if (r_req_src) begin
                        w_state_nxt = ST_CHECK;
                        w_edge_nxt  = 4'd0;
                        w_cyc_nxt   = 16'd0;
                    end else begin
                        w_state_nxt  = ST_SWITCH;
                        w_sel_nxt    = 1'b0;
                        w_settle_nxt = SETTLE_LOAD;
                    end
                end
            end

            ST_CHECK: begin
                w_hold_nxt   = 1'b1;
                w_out_en_nxt = 1'b0;
                // Enough edges beats the timeout when both land together.
                if (r_edge_cnt == EDGE_TARGET) begin
                    w_state_nxt  = ST_SWITCH;
                    w_sel_nxt    = 1'b1;
                    w_settle_nxt = SETTLE_LOAD;
                end else if (r_cyc_cnt == TIMEOUT_LAST) begin
                    w_state_nxt  = ST_RELEASE;
                    w_err_nxt    = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_hold_nxt   = 1'b0;
                    w_out_en_nxt = r_prev_out_en;
                end else begin
                    w_edge_nxt = r_edge_cnt + {3'b000, w_hb_edge};
                    w_cyc_nxt  = r_cyc_cnt + 16'd1;
                end
            end

            ST_SWITCH: begin
                w_hold_nxt   = 1'b1;
                w_out_en_nxt = 1'b0;
                if (r_settle_cnt == 8'd0) begin
                    w_state_nxt  = ST_RELEASE;
                    w_done_nxt   = 1'b1;
                    w_hold_nxt   = 1'b0;
                    w_out_en_nxt = r_req_out_en;
                end else begin
                    w_settle_nxt = r_settle_cnt - 8'd1;
                end
            end

            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_hold_nxt   = 1'b0;
                w_out_en_nxt = 1'b0;
            end
        endcase

        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // Request capture: source, out-enable and the out-enable to restore on failure.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            r_req_src     <= 1'b0;
            r_req_out_en  <= 1'b0;
            r_prev_out_en <= 1'b0;
        end else if (w_accept) begin
            r_req_src     <= I_req_src;
            r_req_out_en  <= I_req_out_en;
            r_prev_out_en <= r_out_en;
        end
    end

    // Heartbeat history and the CHECK / SWITCH counters.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            r_hb_prev    <= 1'b0;
            r_edge_cnt   <= 4'd0;
            r_cyc_cnt    <= 16'd0;
            r_settle_cnt <= 8'd0;
        end else begin
            r_hb_prev    <= I_ext_heartbeat;
            r_edge_cnt   <= w_edge_nxt;
            r_cyc_cnt    <= w_cyc_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            r_sel    <= 1'b0;
            r_out_en <= 1'b0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_sel    <= w_sel_nxt;
            r_out_en <= w_out_en_nxt;
            r_hold   <= w_hold_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign O_req_ready   = r_ready;
    assign O_cclk_sel    = r_sel;
    assign O_cclk_out_en = r_out_en;
    assign O_crypto_hold = r_hold;
    assign O_done        = r_done;
    assign O_err         = r_err;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl: a per-cycle vector table for the
// plain PLL1 request, then hand-written sequences for CHECK success, timeout,
// busy stall with a stray request, and reset in the middle of SWITCH.
module tb_clock_switch_ctrl;

    logic usb_clk = 1'b0;
    logic reset;
    logic I_req_valid;
    logic I_req_src;
    logic I_req_out_en;
    logic O_req_ready;
    logic I_crypto_busy;
    logic I_ext_heartbeat;
    logic O_cclk_sel;
    logic O_cclk_out_en;
    logic O_crypto_hold;
    logic O_done;
    logic O_err;

    int n_cmp = 0;
    int n_bad = 0;

    clock_switch_ctrl #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(1024),
        .MIN_EDGES     (4)
    ) dut (
        .usb_clk        (usb_clk),
        .reset          (reset),
        .I_req_valid    (I_req_valid),
        .I_req_src      (I_req_src),
        .I_req_out_en   (I_req_out_en),
        .O_req_ready    (O_req_ready),
        .I_crypto_busy  (I_crypto_busy),
        .I_ext_heartbeat(I_ext_heartbeat),
        .O_cclk_sel     (O_cclk_sel),
        .O_cclk_out_en  (O_cclk_out_en),
        .O_crypto_hold  (O_crypto_hold),
        .O_done         (O_done),
        .O_err          (O_err)
    );

    always #5 usb_clk = ~usb_clk;

    // inputs for n cycles; exp = {ready, sel, out_en, hold, done, err} after each edge
    typedef struct {
        int         n;
        logic       valid;
        logic       src;
        logic       oen;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {O_req_ready, O_cclk_sel, O_cclk_out_en, O_crypto_hold, O_done, O_err};
    endfunction

    task automatic accept(input logic src, input logic oen, input logic busy);
        I_req_valid   = 1'b1;
        I_req_src     = src;
        I_req_out_en  = oen;
        I_crypto_busy = busy;
        tick();
        I_req_valid = 1'b0;
        chk("accept_ready_low", int'(O_req_ready), 0);
        chk("accept_hold_high", int'(O_crypto_hold), 1);
        chk("accept_oen_low", int'(O_cclk_out_en), 0);
        chk("accept_err_clear", int'(O_err), 0);
    endtask

    // Runs up to max_k cycles after acceptance; records the first cycle the
    // select moves and the cycle O_done is seen. Heartbeat edges land at
    // cycles 9/17/25/33 when toggling is requested.
    task automatic run_seq(input int max_k, input bit toggle_hb, input int busy_until,
                           input int stray_k, output int k_sel, output int k_done,
                           output int oe_bad, output int hold_bad);
        logic sel0;
        sel0     = O_cclk_sel;
        k_sel    = -1;
        k_done   = -1;
        oe_bad   = 0;
        hold_bad = 0;
        for (int k = 1; k <= max_k && k_done < 0; k++) begin
            I_crypto_busy = (k <= busy_until);
            I_req_valid   = (k == stray_k);
            I_req_src     = (k == stray_k);
            if (toggle_hb && (k == 9 || k == 17 || k == 25 || k == 33))
                I_ext_heartbeat = ~I_ext_heartbeat;
            tick();
            if (O_cclk_sel != sel0 && k_sel < 0) k_sel = k;
            if (O_done) begin
                k_done = k;
            end else begin
                if (O_cclk_out_en) oe_bad++;
                if (!O_crypto_hold || O_req_ready) hold_bad++;
            end
        end
        I_req_valid   = 1'b0;
        I_crypto_busy = 1'b0;
    endtask

    initial begin
        int k_sel, k_done, oe_bad, hold_bad;

        vecs[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
        vecs[1] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000100};
        vecs[2] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100};
        vecs[3] = '{15, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100};
        vecs[4] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001010};
        vecs[5] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 6'b101000};

        reset           = 1'b1;
        I_req_valid     = 1'b0;
        I_req_src       = 1'b0;
        I_req_out_en    = 1'b0;
        I_crypto_busy   = 1'b0;
        I_ext_heartbeat = 1'b0;
        #12;
        chk("reset_outputs", int'(outs()), int'(6'b100000));
        reset = 1'b0;

        // PLL1 request, out_en=1: done after E17, idle after E18
        for (int v = 0; v < 6; v++) begin
            I_req_valid  = vecs[v].valid;
            I_req_src    = vecs[v].src;
            I_req_out_en = vecs[v].oen;
            I_crypto_busy = vecs[v].busy;
            for (int c = 0; c < vecs[v].n; c++) begin
                tick();
                I_req_valid = 1'b0;
                chk($sformatf("vec%0d_c%0d", v, c), int'(outs()), int'(vecs[v].exp));
            end
        end

        // external request, heartbeat dead: timeout after 1024 CHECK cycles
        accept(1'b1, 1'b0, 1'b0);
        run_seq(1100, 1'b0, 0, -1, k_sel, k_done, oe_bad, hold_bad);
        chk("timeout_done_cycle", k_done, 1025);
        chk("timeout_sel_unchanged", k_sel, -1);
        chk("timeout_oen_low_before", oe_bad, 0);
        chk("timeout_hold_before", hold_bad, 0);
        chk("timeout_err", int'(O_err), 1);
        chk("timeout_oen_restored", int'(O_cclk_out_en), 1);
        chk("timeout_sel", int'(O_cclk_sel), 0);
        tick();
        chk("timeout_idle", int'(outs()), int'(6'b101001));

        // PLL1 request after failure: err clears on acceptance
        accept(1'b0, 1'b0, 1'b0);
        run_seq(100, 1'b0, 0, -1, k_sel, k_done, oe_bad, hold_bad);
        chk("recover_done_cycle", k_done, 17);
        chk("recover_err", int'(O_err), 0);
        chk("recover_oen", int'(O_cclk_out_en), 0);
        chk("recover_sel", int'(O_cclk_sel), 0);

        // external request, heartbeat alive: 4th edge at E33, SWITCH at E34
        tick();
        accept(1'b1, 1'b1, 1'b0);
        run_seq(100, 1'b1, 0, -1, k_sel, k_done, oe_bad, hold_bad);
        chk("ext_sel_cycle", k_sel, 34);
        chk("ext_done_cycle", k_done, 50);
        chk("ext_oen_low_before", oe_bad, 0);
        chk("ext_hold_before", hold_bad, 0);
        chk("ext_done_outs", int'(outs()), int'(6'b011010));
        tick();
        chk("ext_idle", int'(outs()), int'(6'b111000));

        // busy for 100 cycles with a stray src=1 request at cycle 50
        accept(1'b0, 1'b1, 1'b1);
        run_seq(200, 1'b0, 100, 50, k_sel, k_done, oe_bad, hold_bad);
        chk("busy_sel_cycle", k_sel, 101);
        chk("busy_done_cycle", k_done, 117);
        chk("busy_oen_low_before", oe_bad, 0);
        chk("busy_hold_before", hold_bad, 0);
        chk("busy_done_outs", int'(outs()), int'(6'b001010));
        tick();

        // reset while in SWITCH after an external request
        accept(1'b1, 1'b1, 1'b0);
        run_seq(40, 1'b1, 0, -1, k_sel, k_done, oe_bad, hold_bad);
        chk("rst_pre_sel_cycle", k_sel, 34);
        chk("rst_pre_no_done", k_done, -1);
        reset = 1'b1;
        #1;
        chk("rst_async_outs", int'(outs()), int'(6'b100000));
        tick();
        chk("rst_held_outs", int'(outs()), int'(6'b100000));
        reset = 1'b0;
        tick();
        chk("rst_after_outs", int'(outs()), int'(6'b100000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
